// File: rtl/secded_encoder_tx.sv
// =============================================================================
// secded_encoder_tx : Hamming(12,8) + overall-parity SECDED encoder, serial TX
// Rev 1.0 - initial release
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module secded_encoder_tx (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic [12:0] flip_mask,
    input  logic        data_valid,
    output logic        data_ready,
    output logic        tx_bit,
    output logic        tx_frame,
    output logic        tx_first,
    output logic [12:0] tx_codeword,
    output logic [7:0]  frame_count
);

    localparam logic [3:0] LAST_IDX = 4'd12;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [12:0] frame_q, frame_d;
    logic [12:0] hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic [7:0]  count_q, count_d;

    logic        w_accept;
    logic [12:0] w_injected;

    // Parity bits sit at the power-of-two positions; bit 0 is overall parity.
    function automatic logic [12:0] encode(input logic [7:0] d);
        logic [12:0] c;
        c     = '0;
        c[3]  = d[0];
        c[5]  = d[1];
        c[6]  = d[2];
        c[7]  = d[3];
        c[9]  = d[4];
        c[10] = d[5];
        c[11] = d[6];
        c[12] = d[7];
        c[1]  = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11];
        c[2]  = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11];
        c[4]  = c[5] ^ c[6] ^ c[7] ^ c[12];
        c[8]  = c[9] ^ c[10] ^ c[11] ^ c[12];
        c[0]  = ^c[12:1];
        return c;
    endfunction

    assign data_ready = ~hold_full_q & ~reset;
    assign w_accept   = data_valid & data_ready;
    assign w_injected = encode(data_in) ^ flip_mask;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        frame_d     = frame_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        count_d     = count_q;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    frame_d = w_injected;
                    idx_d   = 4'd0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (idx_q == LAST_IDX) begin
                    count_d = count_q + 8'd1;
                    idx_d   = 4'd0;
                    // A held word takes priority; data_ready is low while it is held.
                    if (hold_full_q) begin
                        frame_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else if (w_accept) begin
                        frame_d = w_injected;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    idx_d = idx_q + 4'd1;
                    if (w_accept) begin
                        hold_d      = w_injected;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= 4'd0;
            frame_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frame_q     <= frame_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            count_q     <= count_d;
        end
    end

    assign tx_frame    = (state_q == ST_SHIFT);
    assign tx_first    = (state_q == ST_SHIFT) && (idx_q == 4'd0);
    assign tx_bit      = (state_q == ST_SHIFT) && frame_q[idx_q];
    assign tx_codeword = frame_q;
    assign frame_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_secded_encoder_tx.sv
// =============================================================================
// tb_secded_encoder_tx : scoreboard bench for the SECDED serial encoder
// Rev 1.0 - initial release
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_secded_encoder_tx;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  data_in = 8'h00;
    logic [12:0] flip_mask = 13'h0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic        tx_bit;
    logic        tx_frame;
    logic        tx_first;
    logic [12:0] tx_codeword;
    logic [7:0]  frame_count;

    int vectors = 0;
    int miscompares = 0;
    logic [12:0] exp_q[$];

    secded_encoder_tx dut (
        .clock       (clock),
        .reset       (reset),
        .data_in     (data_in),
        .flip_mask   (flip_mask),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .tx_bit      (tx_bit),
        .tx_frame    (tx_frame),
        .tx_first    (tx_first),
        .tx_codeword (tx_codeword),
        .frame_count (frame_count)
    );

    always #5 clock = ~clock;

    // Generic Hamming rule: parity bit 2^k covers every position with bit k set.
    function automatic logic [12:0] model(input logic [7:0] d, input logic [12:0] m);
        int dpos[8] = '{3, 5, 6, 7, 9, 10, 11, 12};
        logic [12:0] c;
        logic p;
        c = '0;
        for (int i = 0; i < 8; i++) c[dpos[i]] = d[i];
        for (int k = 0; k < 4; k++) begin
            p = 1'b0;
            for (int pos = 1; pos < 13; pos++)
                if (((pos >> k) & 1) == 1 && pos != (1 << k)) p = p ^ c[pos];
            c[1 << k] = p;
        end
        c[0] = ^c;
        return c ^ m;
    endfunction

    function automatic logic [3:0] syndrome(input logic [12:0] c);
        logic [3:0] s;
        s = 4'd0;
        for (int pos = 1; pos < 13; pos++)
            if (c[pos]) s = s ^ 4'(pos);
        return s;
    endfunction

    // Every accepted word is scored at the negedge before its accepting edge.
    always @(negedge clock) begin
        if (data_valid && data_ready) exp_q.push_back(model(data_in, flip_mask));
    end

    task automatic do_reset();
        reset = 1'b1;
        data_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic drive_word(input logic [7:0] d, input logic [12:0] m, output bit ok);
        int n;
        n = 0;
        @(posedge clock);
        #1;
        data_valid = 1'b1;
        data_in = d;
        flip_mask = m;
        @(negedge clock);
        while (!data_ready && n < 40) begin
            n++;
            @(negedge clock);
        end
        ok = data_ready;
        @(posedge clock);
        #1 data_valid = 1'b0;
    endtask

    task automatic capture_frame(output logic [12:0] cw, output logic [12:0] bits,
                                 output int waited, output bit shape_ok);
        waited = 0;
        shape_ok = 1'b1;
        cw = '0;
        bits = '0;
        @(negedge clock);
        while (!(tx_frame && tx_first) && waited < 40) begin
            waited++;
            @(negedge clock);
        end
        if (waited < 40) begin
            cw = tx_codeword;
            for (int i = 0; i < 13; i++) begin
                if (i > 0) @(negedge clock);
                bits[i] = tx_bit;
                if (!tx_frame || (tx_first != (i == 0)) || tx_codeword !== cw) shape_ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        vectors++; if (tx_frame !== 1'b0) begin miscompares++; $display("FAIL reset_tx_frame got %b want 0", tx_frame); end
        vectors++; if (tx_first !== 1'b0) begin miscompares++; $display("FAIL reset_tx_first got %b want 0", tx_first); end
        vectors++; if (tx_bit !== 1'b0) begin miscompares++; $display("FAIL reset_tx_bit got %b want 0", tx_bit); end
        vectors++; if (tx_codeword !== 13'h0) begin miscompares++; $display("FAIL reset_codeword got %h want 0000", tx_codeword); end
        vectors++; if (frame_count !== 8'h0) begin miscompares++; $display("FAIL reset_count got %0d want 0", frame_count); end
        vectors++; if (data_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready_in_reset got %b want 0", data_ready); end
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        vectors++; if (data_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready_after got %b want 1", data_ready); end
    endtask

    task automatic test_vectors();
        logic [7:0]  din [3] = '{8'h00, 8'hFF, 8'h01};
        logic [12:0] msk [3] = '{13'h0000, 13'h0000, 13'h0020};
        logic [12:0] lit [3] = '{13'h0000, 13'h1EEE, 13'h002F};
        logic [12:0] cw, bits, e;
        int waited;
        bit ok, shape;
        do_reset();
        for (int v = 0; v < 3; v++) begin
            drive_word(din[v], msk[v], ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL vec%0d_ready got 0 want 1", v); end
            capture_frame(cw, bits, waited, shape);
            vectors++; if (waited !== 0) begin miscompares++; $display("FAIL vec%0d_latency got %0d want 0 extra cycles", v, waited); end
            vectors++; if (!shape) begin miscompares++; $display("FAIL vec%0d_frame_shape got bad want 13 framed bits", v); end
            e = 13'h0;
            vectors++;
            if (exp_q.size() == 0) begin miscompares++; $display("FAIL vec%0d_scoreboard got empty want entry", v); end
            else e = exp_q.pop_front();
            vectors++; if (cw !== e) begin miscompares++; $display("FAIL vec%0d_model got %h want %h", v, cw, e); end
            vectors++; if (cw !== lit[v]) begin miscompares++; $display("FAIL vec%0d_codeword got %h want %h", v, cw, lit[v]); end
            vectors++; if (bits !== lit[v]) begin miscompares++; $display("FAIL vec%0d_serial got %h want %h", v, bits, lit[v]); end
        end
        vectors++; if (syndrome(13'h002F) !== syndrome(cw)) begin miscompares++; $display("FAIL vec_err_syndrome got %0d want 5", syndrome(cw)); end
        vectors++; if (syndrome(cw) !== 4'd5) begin miscompares++; $display("FAIL vec_err_position got %0d want 5", syndrome(cw)); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  w  [3] = '{8'hA5, 8'h3C, 8'h7E};
        logic [12:0] mk [3] = '{13'h0000, 13'h1000, 13'h0000};
        logic [12:0] cw [3];
        logic [12:0] bits [3];
        int wt [3];
        bit sh [3];
        int low_cnt;
        bit drv_ok;
        logic [12:0] e;
        low_cnt = 0;
        drv_ok = 1'b1;
        do_reset();
        fork
            begin
                int n;
                @(posedge clock);
                #1 data_valid = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    data_in = w[k];
                    flip_mask = mk[k];
                    n = 0;
                    @(negedge clock);
                    while (!data_ready && n < 60) begin
                        n++;
                        low_cnt++;
                        @(negedge clock);
                    end
                    if (!data_ready) drv_ok = 1'b0;
                    @(posedge clock);
                    #1;
                end
                data_valid = 1'b0;
            end
            begin
                for (int f = 0; f < 3; f++) capture_frame(cw[f], bits[f], wt[f], sh[f]);
            end
        join
        vectors++; if (!drv_ok) begin miscompares++; $display("FAIL b2b_accept got timeout want 3 accepts"); end
        vectors++; if (low_cnt !== 12) begin miscompares++; $display("FAIL b2b_ready_low got %0d want 12 cycles", low_cnt); end
        vectors++; if (wt[0] >= 40) begin miscompares++; $display("FAIL b2b_first_frame got timeout want frame"); end
        for (int f = 0; f < 3; f++) begin
            if (f > 0) begin
                vectors++; if (wt[f] !== 0) begin miscompares++; $display("FAIL b2b_gap%0d got %0d want 0", f, wt[f]); end
            end
            vectors++; if (!sh[f]) begin miscompares++; $display("FAIL b2b_shape%0d got bad want 13 framed bits", f); end
            e = 13'h0;
            vectors++;
            if (exp_q.size() == 0) begin miscompares++; $display("FAIL b2b_scoreboard%0d got empty want entry", f); end
            else e = exp_q.pop_front();
            vectors++; if (cw[f] !== model(w[f], mk[f])) begin miscompares++; $display("FAIL b2b_order%0d got %h want %h", f, cw[f], model(w[f], mk[f])); end
            vectors++; if (cw[f] !== e) begin miscompares++; $display("FAIL b2b_codeword%0d got %h want %h", f, cw[f], e); end
            vectors++; if (bits[f] !== e) begin miscompares++; $display("FAIL b2b_serial%0d got %h want %h", f, bits[f], e); end
        end
        vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL b2b_extra got %0d want 0 pending", exp_q.size()); end
        @(negedge clock);
        vectors++; if (frame_count !== 8'd3) begin miscompares++; $display("FAIL b2b_count got %0d want 3", frame_count); end
        vectors++; if (tx_frame !== 1'b0) begin miscompares++; $display("FAIL b2b_idle got %b want 0", tx_frame); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        bit seen;
        do_reset();
        drive_word(8'h11, 13'h0, ok);
        drive_word(8'h22, 13'h0, ok);
        @(negedge clock);
        vectors++; if (data_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_held got ready %b want 0", data_ready); end
        repeat (4) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        vectors++; if (tx_frame !== 1'b1) begin miscompares++; $display("FAIL midrst_in_frame got %b want 1", tx_frame); end
        @(posedge clock);
        @(negedge clock);
        vectors++; if ({tx_frame, tx_first, tx_bit} !== 3'b000) begin miscompares++; $display("FAIL midrst_outputs got %b want 000", {tx_frame, tx_first, tx_bit}); end
        vectors++; if (tx_codeword !== 13'h0) begin miscompares++; $display("FAIL midrst_codeword got %h want 0000", tx_codeword); end
        vectors++; if (frame_count !== 8'd0) begin miscompares++; $display("FAIL midrst_count got %0d want 0", frame_count); end
        @(posedge clock);
        #1 reset = 1'b0;
        exp_q.delete();
        @(negedge clock);
        vectors++; if (data_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready got %b want 1", data_ready); end
        seen = 1'b0;
        repeat (30) begin
            @(negedge clock);
            if (tx_frame) seen = 1'b1;
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL midrst_resume got frame want none"); end
        vectors++; if (frame_count !== 8'd0) begin miscompares++; $display("FAIL midrst_count_after got %0d want 0", frame_count); end
    endtask

    task automatic test_exhaustive_wrap();
        logic [12:0] cw, bits, e;
        int waited;
        bit ok, shape;
        do_reset();
        for (int b = 0; b < 256; b++) begin
            drive_word(8'(b), 13'h0, ok);
            capture_frame(cw, bits, waited, shape);
            vectors++; if (!ok || waited >= 40 || !shape) begin miscompares++; $display("FAIL exh%0d_frame got ok=%0b wait=%0d shape=%0b want 1/0/1", b, ok, waited, shape); end
            e = 13'h0;
            vectors++;
            if (exp_q.size() == 0) begin miscompares++; $display("FAIL exh%0d_scoreboard got empty want entry", b); end
            else e = exp_q.pop_front();
            vectors++; if (cw !== e || bits !== e) begin miscompares++; $display("FAIL exh%0d_codeword got %h/%h want %h", b, cw, bits, e); end
            vectors++; if (syndrome(cw) !== 4'd0) begin miscompares++; $display("FAIL exh%0d_syndrome got %0d want 0", b, syndrome(cw)); end
            vectors++; if ((^cw) !== 1'b0) begin miscompares++; $display("FAIL exh%0d_parity got 1 want 0", b); end
            @(negedge clock);
            vectors++; if (frame_count !== 8'(b + 1)) begin miscompares++; $display("FAIL exh%0d_count got %0d want %0d", b, frame_count, 8'(b + 1)); end
        end
        vectors++; if (frame_count !== 8'd0) begin miscompares++; $display("FAIL wrap_count got %0d want 0", frame_count); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_mid_frame();
        test_exhaustive_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/secded_encoder_tx.md
SECDED_ENCODER_TX -- requirements
Module: secded_encoder_tx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state updates on the rising edge of clock.
REQ-002 clock  input  1  system clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 data_in  input  8  data byte to encode.
REQ-005 flip_mask  input  13  error-injection mask, captured with data_in; bit i=1 inverts codeword bit i.
REQ-006 data_valid  input  1  data_in and flip_mask are valid.
REQ-007 data_ready  output  1  block accepts a word on this cycle; transfer occurs when data_valid && data_ready.
REQ-008 tx_bit  output  1  serial codeword bit, bit 0 first.
REQ-009 tx_frame  output  1  high for each of the 13 bit-times of a frame.
REQ-010 tx_first  output  1  high only during bit 0 of a frame.
REQ-011 tx_codeword  output  13  full codeword of the frame in flight; stable for all 13 bit-times.
REQ-012 frame_count  output  8  number of completed frames, modulo 256.

Function
REQ-013 Encoding: codeword bits 3,5,6,7,9,10,11,12 SHALL hold data_in[0..7] in that order.
REQ-014 Bit 1 = XOR(bits 3,5,7,9,11); bit 2 = XOR(3,6,7,10,11); bit 4 = XOR(5,6,7,12); bit 8 = XOR(9,10,11,12).
REQ-015 Bit 0 SHALL make the XOR of all 13 bits equal 0 (even overall parity).
REQ-016 After encoding, the codeword SHALL be XORed with the captured flip_mask; tx_codeword reflects the injected value.
REQ-017 Storage: one shift register (active frame) plus one holding register (encoded codeword + full flag).
REQ-018 FSM states: IDLE (no frame) and SHIFT (frame in flight, bit index 0..12).
REQ-019 IDLE + accept: at that edge the encoded word loads into the shifter; state becomes SHIFT at index 0 the next cycle. Latency from accept edge to tx_first is 1 cycle.
REQ-020 SHIFT: tx_bit = tx_codeword[index]; the index increments each cycle.
REQ-021 At index 12 with the holding register full, the held word loads and index 0 follows with no gap cycle; the holding register empties.
REQ-022 At index 12 with the holding register empty and an accept on the same cycle, the accepted word loads directly into the shifter, with no gap cycle.
REQ-023 At index 12 with no held word and no accept, the FSM returns to IDLE.
REQ-024 Accept during SHIFT at index 0..11 SHALL write the holding register and set it full.
REQ-025 data_ready = NOT hold_full AND NOT reset (combinational).
REQ-026 In IDLE, tx_bit, tx_frame, tx_first are 0.
REQ-027 frame_count increments on the edge ending index 12, wrapping 255 -> 0.
REQ-028 data_valid with data_ready low SHALL be ignored; the upstream holds the word.

Reset
REQ-029 Reset SHALL force IDLE, index 0, empty holding register, tx_codeword=0, tx_bit=0, tx_frame=0, tx_first=0, frame_count=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame and discard any held word; no partial frame resumes afterward.
REQ-031 data_ready SHALL be 0 while reset is high and 1 the first cycle after reset deasserts.

Verification
REQ-032 data_in=8'h00, mask=0 -> tx_codeword=13'h0000, 13 tx_bit zeros, tx_first one cycle after accept.
REQ-033 data_in=8'hFF, mask=0 -> tx_codeword=13'h1EEE, serial sequence 0,1,1,1,0,1,1,1,0,1,1,1,1.
REQ-034 data_in=8'h01, mask=13'h0020 -> encoded 13'h000F, tx_codeword=13'h002F (single-bit error at position 5).
REQ-035 Three words offered back-to-back with data_valid held high -> first loads immediately, second is held, data_ready drops until index 12, frames are contiguous (39 tx_frame cycles, no gap), frame_count=3.
REQ-036 Reset pulsed at index 6 with a held word -> outputs return to 0 next cycle, frame_count unchanged from its pre-frame value of 0, held word never transmitted.
REQ-037 Send 256 frames -> frame_count wraps to 0; exhaustively encode all 256 bytes and check zero syndrome and even overall parity.
